seq_magnitude_compare: RTL

- Parametrised, multi-cycle magnitude comparator. Successor to the 8-bit combinational byte compare.
- Compares two WIDTH-bit operands CHUNK bits per clock, MSB chunk first, and stops at the first chunk that differs.
- Supports unsigned and two's-complement signed modes, with a start/busy/done handshake.
- Sits in the ALU datapath as the compare unit for operands wider than one byte.

---
 rtl/alu_cmp_pkg.sv | 19 +
 rtl/chunk_compare.sv | 34 +++
 rtl/seq_magnitude_compare.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_cmp_pkg.sv
// Purpose: shared types and result encoding for the sequential magnitude compare unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cmp_state_t;

    // Result vector ordering is {equal, greater, less}; exactly one bit set once valid.
    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_NONE = 3'b000;
    localparam cmp_res_t CMP_EQ   = 3'b100;
    localparam cmp_res_t CMP_GT   = 3'b010;
    localparam cmp_res_t CMP_LT   = 3'b001;

endpackage

// File: rtl/chunk_compare.sv
// Purpose: combinational compare of one CHUNK-wide slice, optionally two's-complement.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   x, y      : CHUNK-wide slices to compare
//   is_signed : treat the slices as two's-complement
//   eq/gt/lt  : x == y, x > y, x < y
module chunk_compare #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             is_signed,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    logic [CHUNK-1:0] flip;
    logic [CHUNK-1:0] xm;
    logic [CHUNK-1:0] ym;

    assign flip = is_signed ? (CHUNK'(1) << (CHUNK - 1)) : '0;
    assign xm   = x ^ flip;
    assign ym   = y ^ flip;

    assign eq = (x == y);
    assign gt = (xm > ym);
    assign lt = (xm < ym);

endmodule

// File: rtl/seq_magnitude_compare.sv
// Purpose: multi-cycle WIDTH-bit magnitude compare, CHUNK bits per cycle, MSB chunk first, early exit.
// Latency: min(k+1, NCHUNK) cycles from start acceptance to done (k = identical leading chunks).
// Backpressure: start is only accepted in IDLE; start while busy is dropped, never queued.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : request a compare (sampled only when idle)
//   signed_mode      : 1 = two's-complement, 0 = unsigned (latched with start)
//   a, b             : operands (latched with start)
//   busy             : compare in progress
//   done             : one-cycle pulse when the result becomes valid
//   equal/greater/less : result, held from done until the next accepted start
module seq_magnitude_compare
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             less
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NCHUNK - 1);

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    cmp_res_t         res_q, res_d;

    // Chunk views of the latched operands; element NCHUNK-1 is the MSB chunk.
    logic [NCHUNK-1:0][CHUNK-1:0] a_v;
    logic [NCHUNK-1:0][CHUNK-1:0] b_v;
    logic                         c_eq, c_gt, c_lt;
    logic                         c_signed;

    assign a_v = a_q;
    assign b_v = b_q;

    // Only the top chunk carries the sign; lower chunks are plain magnitude.
    assign c_signed = sgn_q && (idx_q == TOP_IDX);

    chunk_compare #(
        .CHUNK(CHUNK)
    ) u_chunk_compare (
        .x        (a_v[idx_q]),
        .y        (b_v[idx_q]),
        .is_signed(c_signed),
        .eq       (c_eq),
        .gt       (c_gt),
        .lt       (c_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= CMP_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = signed_mode;
                    idx_d   = TOP_IDX;
                    res_d   = CMP_NONE;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!c_eq) begin
                    // gt and lt are exclusive whenever the chunks differ.
                    res_d   = c_gt ? CMP_GT : (c_lt ? CMP_LT : CMP_NONE);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    res_d   = CMP_EQ;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign {equal, greater, less} = res_q;

endmodule
